// File: rtl/bp_trace_pkg.sv
// Shared types for the commit-stream trace packetizer: packet type codes and
// the drop/resync state encoding.
package bp_trace_pkg;

    localparam int unsigned TRACE_TYPE_W = 2;

    typedef enum logic [TRACE_TYPE_W-1:0] {
        TT_SYNC      = 2'd0,
        TT_BRANCH    = 2'd1,
        TT_FULL_ADDR = 2'd2,
        TT_OVERFLOW  = 2'd3
    } trace_type_e;

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_DROP   = 1'b1
    } trace_state_e;

endpackage

// File: rtl/bp_trace_fifo.sv
// Show-ahead synchronous FIFO for trace packets. Full/empty come from the
// registered occupancy, so a pop never frees a slot for a same-cycle write.
module bp_trace_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push, pop;

    assign full_o  = (count_q == DEPTH_CNT);
    assign empty_o = (count_q == '0);
    assign push    = wr_en_i && !full_o;
    assign pop     = rd_en_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= wr_data_i;
    end

    // Empty head reads as zero so the output is clean straight out of reset.
    assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/bp_trace_packetizer.sv
// Commit-stream trace packetizer: classifies retired PCs into SYNC / BRANCH /
// FULL_ADDR / OVERFLOW packets and queues them behind a valid/ready port.
module bp_trace_packetizer
    import bp_trace_pkg::*;
#(
    parameter int PC_WIDTH    = 32,
    parameter int INSTR_BYTES = 4,
    parameter int DELTA_WIDTH = 16,
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_PERIOD = 256,
    parameter int DROP_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic                  enable_i,
    input  logic                  commit_valid_i,
    input  logic [PC_WIDTH-1:0]   commit_pc_i,
    output logic [PC_WIDTH+1:0]   trace_data_o,
    output logic                  trace_valid_o,
    input  logic                  trace_ready_i,
    input  logic                  drop_clear_i,
    output logic [DROP_WIDTH-1:0] drop_count_o
);

    typedef struct packed {
        trace_type_e         typ;
        logic [PC_WIDTH-1:0] payload;
    } trace_pkt_t;

    localparam int SCW = $clog2(SYNC_PERIOD + 2);
    localparam logic [SCW-1:0]        SYNC_LAST = (SYNC_PERIOD == 0) ? '0 : SCW'(SYNC_PERIOD - 1);
    localparam logic [PC_WIDTH-1:0]   STEP      = PC_WIDTH'(INSTR_BYTES);
    localparam logic [DROP_WIDTH-1:0] DROP_MAX  = '1;

    trace_state_e          state_q, state_d;
    logic [PC_WIDTH-1:0]   last_pc_q, last_pc_d;
    logic [SCW-1:0]        sync_cnt_q, sync_cnt_d;
    logic                  need_sync_q, need_sync_d;
    logic [DROP_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

    logic [PC_WIDTH-1:0] delta;
    logic                disc, fits, sync_due;
    logic                gen, drop_inc, fifo_wr, fifo_full, fifo_empty;
    trace_pkt_t          wr_pkt;

    assign delta    = commit_pc_i - last_pc_q;
    assign disc     = (delta != STEP) && (delta != '0);
    assign fits     = (delta == {{(PC_WIDTH-DELTA_WIDTH){delta[DELTA_WIDTH-1]}}, delta[DELTA_WIDTH-1:0]});
    assign sync_due = need_sync_q || ((SYNC_PERIOD != 0) && (sync_cnt_q == SYNC_LAST));

    always_comb begin
        state_d     = state_q;
        last_pc_d   = last_pc_q;
        sync_cnt_d  = sync_cnt_q;
        need_sync_d = need_sync_q;
        gen         = 1'b0;
        drop_inc    = 1'b0;
        fifo_wr     = 1'b0;
        wr_pkt      = '{typ: TT_SYNC, payload: '0};

        if (!enable_i) begin
            state_d     = ST_NORMAL;
            need_sync_d = 1'b1;
        end else if (commit_valid_i) begin
            last_pc_d = commit_pc_i;
            if (state_q == ST_DROP) begin
                if (fifo_full) begin
                    drop_inc = 1'b1;
                end else begin
                    fifo_wr = 1'b1;
                    wr_pkt  = '{typ: TT_OVERFLOW, payload: commit_pc_i};
                    state_d = ST_NORMAL;
                end
            end else begin
                if (sync_due) begin
                    gen    = 1'b1;
                    wr_pkt = '{typ: TT_SYNC, payload: commit_pc_i};
                end else if (disc && fits) begin
                    gen    = 1'b1;
                    wr_pkt = '{typ: TT_BRANCH,
                               payload: {{(PC_WIDTH-DELTA_WIDTH){1'b0}}, delta[DELTA_WIDTH-1:0]}};
                end else if (disc) begin
                    gen    = 1'b1;
                    wr_pkt = '{typ: TT_FULL_ADDR, payload: commit_pc_i};
                end
                if (gen && fifo_full) begin
                    drop_inc = 1'b1;
                    state_d  = ST_DROP;
                end else begin
                    fifo_wr = gen;
                end
            end

            // Only an enqueued SYNC/OVERFLOW re-anchors the decoder; a dropped one does not.
            if (fifo_wr && (wr_pkt.typ == TT_SYNC || wr_pkt.typ == TT_OVERFLOW)) begin
                sync_cnt_d = '0;
                if (wr_pkt.typ == TT_SYNC) need_sync_d = 1'b0;
            end else if ((SYNC_PERIOD != 0) && (sync_cnt_q != SYNC_LAST)) begin
                sync_cnt_d = sync_cnt_q + 1'b1;
            end
        end

        drop_cnt_d = drop_cnt_q;
        if (drop_clear_i)                              drop_cnt_d = drop_inc ? DROP_WIDTH'(1) : '0;
        else if (drop_inc && (drop_cnt_q != DROP_MAX)) drop_cnt_d = drop_cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= ST_NORMAL;
            last_pc_q   <= '0;
            sync_cnt_q  <= '0;
            need_sync_q <= 1'b1;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            last_pc_q   <= last_pc_d;
            sync_cnt_q  <= sync_cnt_d;
            need_sync_q <= need_sync_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    bp_trace_fifo #(
        .WIDTH (PC_WIDTH + 2),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_ni    (reset_n_i),
        .wr_en_i   (fifo_wr),
        .wr_data_i (wr_pkt),
        .rd_en_i   (trace_valid_o && trace_ready_i),
        .rd_data_o (trace_data_o),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    assign trace_valid_o = !fifo_empty;
    assign drop_count_o  = drop_cnt_q;

endmodule

// File: tb/tb_bp_trace_packetizer.sv
// Directed bench for bp_trace_packetizer: one default instance plus one with a
// short sync period, sharing stimulus.
module tb_bp_trace_packetizer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        enable = 1'b1;
    logic        commit_valid = 1'b0;
    logic [31:0] commit_pc = '0;
    logic        ready = 1'b1;
    logic        drop_clear = 1'b0;

    logic [33:0] data_a, data_b;
    logic        valid_a, valid_b;
    logic [15:0] drop_a, drop_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    bp_trace_packetizer #(
        .PC_WIDTH(32), .INSTR_BYTES(4), .DELTA_WIDTH(16),
        .FIFO_DEPTH(8), .SYNC_PERIOD(256), .DROP_WIDTH(16)
    ) dut_a (
        .clk_i(clk), .reset_n_i(reset_n), .enable_i(enable),
        .commit_valid_i(commit_valid), .commit_pc_i(commit_pc),
        .trace_data_o(data_a), .trace_valid_o(valid_a), .trace_ready_i(ready),
        .drop_clear_i(drop_clear), .drop_count_o(drop_a)
    );

    bp_trace_packetizer #(
        .PC_WIDTH(32), .INSTR_BYTES(4), .DELTA_WIDTH(16),
        .FIFO_DEPTH(8), .SYNC_PERIOD(4), .DROP_WIDTH(16)
    ) dut_b (
        .clk_i(clk), .reset_n_i(reset_n), .enable_i(enable),
        .commit_valid_i(commit_valid), .commit_pc_i(commit_pc),
        .trace_data_o(data_b), .trace_valid_o(valid_b), .trace_ready_i(ready),
        .drop_clear_i(drop_clear), .drop_count_o(drop_b)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pk(input logic [1:0] t, input logic [31:0] p);
        return {30'b0, t, p};
    endfunction

    task automatic do_reset();
        reset_n = 1'b0; commit_valid = 1'b0; enable = 1'b1; ready = 1'b1; drop_clear = 1'b0;
        #2;
        chk("rst_valid", valid_a, 0);
        chk("rst_data",  data_a,  0);
        chk("rst_drop",  drop_a,  0);
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    task automatic commit(input logic [31:0] pc);
        commit_valid = 1'b1;
        commit_pc    = pc;
        @(posedge clk); #1;
        commit_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    logic [31:0] pc;
    logic [63:0] held_data;
    logic        held;
    logic [63:0] exp_q[$];

    initial begin
        #1;
        do_reset();

        // Reset then sequential run ending in a branch.
        commit(32'h1000); chk("t1_sync", data_a, pk(0, 32'h1000)); chk("t1_valid", valid_a, 1);
        commit(32'h1004); chk("t1_seq1", valid_a, 0);
        commit(32'h1008); chk("t1_seq2", valid_a, 0);
        commit(32'h2000); chk("t1_branch", data_a, pk(1, 32'h0000_0FF8));

        // Delta range and PC wrap.
        commit(32'h1000);
        commit(32'h0F00);      chk("t2_neg_branch", data_a, pk(1, 32'h0000_FF00));
        commit(32'h1000);
        commit(32'h0100_0000); chk("t2_full_addr", data_a, pk(2, 32'h0100_0000));
        commit(32'hFFFF_FFFC); chk("t2_full_hi", data_a, pk(2, 32'hFFFF_FFFC));
        commit(32'h0000_0000); chk("t2_wrap_seq", valid_a, 0);

        // Periodic sync on the SYNC_PERIOD=4 instance.
        do_reset();
        commit(32'h0);  chk("t3_sync0", data_b, pk(0, 32'h0));
        commit(32'h4);  chk("t3_q4", valid_b, 0);
        commit(32'h8);  chk("t3_q8", valid_b, 0);
        commit(32'hC);  chk("t3_qC", valid_b, 0);
        commit(32'h10); chk("t3_sync10", data_b, pk(0, 32'h10)); chk("t3_a_quiet", valid_a, 0);

        // Overflow: fill, drop two, pop one, resync.
        do_reset();
        ready = 1'b0;
        for (int k = 1; k <= 10; k++) commit(32'(k * 32'h100));
        chk("t4_drop2", drop_a, 2);
        chk("t4_head",  data_a, pk(0, 32'h100));
        ready = 1'b1; @(posedge clk); #1; ready = 1'b0;
        chk("t4_head_after_pop", data_a, pk(1, 32'h100));
        commit(32'h5000);
        chk("t4_drop_kept", drop_a, 2);
        ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            chk("t4_drain_branch", data_a, pk(1, 32'h100));
            @(posedge clk); #1;
        end
        chk("t4_overflow", data_a, pk(3, 32'h5000));
        @(posedge clk); #1;
        chk("t4_empty", valid_a, 0);

        // Backpressure: ready toggles while commits stream in.
        do_reset();
        exp_q.delete();
        held = 1'b0; held_data = '0; pc = 32'h8000;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (cyc < 12) begin
                if (cyc == 0) exp_q.push_back(pk(0, pc));
                else begin
                    pc = pc + 32'(16 * (cyc + 1));
                    exp_q.push_back(pk(1, 32'(16 * (cyc + 1))));
                end
                commit_valid = 1'b1; commit_pc = pc;
            end else begin
                commit_valid = 1'b0;
            end
            ready = cyc[0];
            if (held) chk("t5_hold", data_a, held_data);
            held = valid_a && !ready;
            held_data = 64'(data_a);
            if (valid_a && ready) begin
                if (exp_q.size() > 0) chk("t5_data", data_a, exp_q.pop_front());
                else chk("t5_extra_pkt", 1, 0);
            end
            @(posedge clk); #1;
        end
        commit_valid = 1'b0;
        chk("t5_all_seen", 64'(exp_q.size()), 0);
        chk("t5_no_drop", drop_a, 0);

        // Enable low forces a resync on the next commit.
        do_reset();
        commit(32'h3000); chk("t6_sync", data_a, pk(0, 32'h3000));
        enable = 1'b0;
        commit_valid = 1'b1; commit_pc = 32'h7777_0000;
        idle(3);
        commit_valid = 1'b0;
        chk("t6_ignored", valid_a, 0);
        enable = 1'b1;
        commit(32'h3004); chk("t6_resync", data_a, pk(0, 32'h3004));
        commit(32'h3008); chk("t6_seq", valid_a, 0);

        // Drop clear racing an increment, then clear alone, then mid-stream reset.
        do_reset();
        ready = 1'b0;
        for (int k = 1; k <= 10; k++) commit(32'(k * 32'h100));
        chk("t7_drop2", drop_a, 2);
        drop_clear = 1'b1;
        commit(32'hB00);
        chk("t7_clear_inc_a", drop_a, 1);
        chk("t7_clear_inc_b", drop_b, 1);
        idle(1);
        drop_clear = 1'b0;
        chk("t7_clear", drop_a, 0);
        chk("t7_still_full", valid_a, 1);
        do_reset();
        idle(1);
        chk("t7_post_reset_empty", valid_a, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
